pwm_multi: RTL
==============

# pwm_multi

Parametrised multi-channel PWM generator, successor to the fixed 4×8-bit `pwm` block. It has CH channels of W-bit duty and a programmable period, plus edge- or center-aligned counting. Duty, period and mode are double-buffered so that updates take effect only at a period boundary and never produce glitches. It sits behind the peripheral register file, which supplies the packed duty word and an update strobe.

## Interface
- CH, 4, number of PWM channels (1..16)
- W, 8, counter/duty/period width in bits (4..16)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- en_i  in  1  1 = run; 0 = counter held at 0, all pwm_o low
- center_i  in  1  mode request: 0 = edge-aligned, 1 = center-aligned
- period_i  in  W  period request P (counts per half/whole cycle, see Operation)
- duty_i  in  CH*W  packed duty requests, channel i in bits [i*W +: W]
- update_i  in  1  one-cycle strobe: capture duty_i/period_i/center_i into staging
- pwm_o  out  CH  registered PWM outputs
- start_o  out  1  registered one-cycle pulse marking the first output cycle of each period
- pending_o  out  1  staged values not yet transferred to shadow

## Operation
- Three register tiers: inputs → staging (on update_i) → shadow (at boundary). Only shadow values drive counting and compare.
- update_i sets pending. A later update_i before the boundary overwrites staging; the last one wins.
- Boundary = last count of a period. Edge mode: cnt==P-1. Center mode: down phase with cnt==0.
- At the boundary, if pending: shadow ← staging and pending clears. If update_i arrives in the boundary cycle itself, shadow loads directly from the inputs that cycle (bypass) and pending stays clear.
- Edge mode: cnt counts 0,1,…,P-1 and wraps to 0. Period is P cycles. pwm_o[i] = (cnt < D_i).
- Center mode: cnt counts up 0..P-1, then down P-1..0. Period is 2P cycles. pwm_o[i] = (cnt < D_i), giving 2·D_i high cycles centred on the up/down turn.
- D_i ≥ P gives constant high. D_i = 0 gives constant low.
- Shadow P = 0: counter held at 0, outputs low, and every cycle counts as a boundary, so pending transfers immediately.
- en_i = 0: cnt ← 0, direction ← up, outputs low, start_o low. Pending transfers on any cycle (immediate load while disabled).
- Mode change takes effect only via shadow at a boundary. After a transfer the counter restarts at 0, counting up.
- Compare is unsigned and W bits wide. No arithmetic wider than W+1.

## Timing
- Reset (rst = 0 at a clock edge):
  - staging and shadow duty/period cleared to 0, mode cleared to edge
  - cnt = 0, direction = up, pending = 0
  - pwm_o = 0, start_o = 0
- Reset mid-period aborts immediately. There is no completion of the current period.
- Output latency is 1 cycle: pwm_o and start_o at edge t+1 reflect cnt and shadow at edge t.
- start_o is high in the output cycle corresponding to cnt==0 at the start of each period (up phase in center mode). It is not asserted while P = 0 or en_i = 0.
- en_i rising: the first counted cycle is cnt = 0. start_o and pwm_o for it appear 1 cycle later.
- update_i to new values visible: at most one full period plus 1 cycle. With P = 0 or en_i = 0, visible 2 cycles after update_i.
- pending_o is registered. It rises the cycle after update_i and falls the cycle after transfer.

## Structure
- Package pwm_multi_pkg holds:
  - mode enum (PWM_EDGE, PWM_CENTER)
  - default CH/W localparams
  - a function for extracting channel i from the packed duty word
- Sub-module pwm_channel, instantiated CH times via generate. It contains the staging duty, shadow duty, compare and output flop for one channel. It takes cnt, load_stage and load_shadow from the top.
- The top holds the counter, direction, the period/mode shadows, the pending flag, boundary detection and start_o.

## Test plan
- Reset, then en_i = 1, CH = 4, W = 8, edge mode, P = 200, duties {0,10,250,100} (ch3..ch0), update_i once → shadow loads immediately (P was 0). Required response:
  - ch0 high 100 of every 200 cycles
  - ch1 constant high
  - ch2 high 10 cycles
  - ch3 constant low
  - start_o every 200 cycles
- Mid-period (cnt = 50) update to duties {0,15,150,60} → current period unchanged. The next period begins with ch0 = 60 and ch2 = 15 high cycles. pending_o is high from update until the boundary.
- Center mode, P = 100, ch0 D = 30 → ch0 high for 60 consecutive cycles centred on the turn (up cnt 0..29 and down 29..0 contiguous across the period wrap). start_o every 200 cycles.
- update_i asserted exactly on the boundary cycle with P 200 → 50 → the new period is 50 with no extra 200-count, and pending_o never rises.
- rst asserted for 1 cycle mid-period with ch0 high → next cycle pwm_o = 0, start_o = 0, pending_o = 0. Outputs stay low until reconfigured (shadow P = 0).
- en_i dropped for 5 cycles mid-period → pwm_o low within 1 cycle. On re-enable, cnt restarts at 0 and start_o pulses 1 cycle after en_i rises.

Source files
------------

// File: rtl/pwm_multi_pkg.sv
// Shared types, defaults and helpers for the multi-channel PWM generator.
package pwm_multi_pkg;

  // Default geometry of the generator (and the legal upper bounds).
  localparam int unsigned PWM_CH_DEFAULT = 4;
  localparam int unsigned PWM_W_DEFAULT  = 8;
  localparam int unsigned PWM_CH_MAX     = 16;
  localparam int unsigned PWM_W_MAX      = 16;

  // Counting mode held in the staging and shadow tiers.
  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  // Counter direction; edge mode only ever counts up.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  // Widest packed duty word any legal configuration can present.
  typedef logic [PWM_CH_MAX*PWM_W_MAX-1:0] duty_bus_t;

  // Extract channel idx (w bits wide) from a zero-extended packed duty word.
  function automatic logic [PWM_W_MAX-1:0] duty_of(input duty_bus_t   bus,
                                                   input int unsigned idx,
                                                   input int unsigned w);
    duty_bus_t            shifted;
    logic [PWM_W_MAX-1:0] mask;
    shifted = bus >> (idx * w);
    mask    = PWM_W_MAX'((32'd1 << w) - 32'd1);
    return shifted[PWM_W_MAX-1:0] & mask;
  endfunction

endpackage : pwm_multi_pkg

// File: rtl/pwm_channel.sv
// One PWM channel: staging duty, shadow duty, compare and registered output.
module pwm_channel
  import pwm_multi_pkg::*;
#(
  parameter int unsigned W = PWM_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,           // synchronous, active-low
  input  logic [W-1:0] cnt_i,         // shared period counter
  input  logic [W-1:0] duty_i,        // this channel's duty request
  input  logic         load_stage_i,  // capture duty_i into staging
  input  logic         load_shadow_i, // transfer into shadow (bypass when load_stage_i too)
  input  logic         active_i,      // enabled and non-zero period
  output logic         pwm_o
);

  logic [W-1:0] stage_q, stage_d;
  logic [W-1:0] shadow_q, shadow_d;
  logic         pwm_q, pwm_d;

  // Next-state for both duty tiers and the compare result.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it holding its old value and infer a latch.
    stage_d  = stage_q;
    shadow_d = shadow_q;
    if (load_stage_i) begin
      stage_d = duty_i;
    end
    if (load_shadow_i) begin
      // A strobe in the transfer cycle itself skips staging and loads the
      // freshest request directly.
      shadow_d = load_stage_i ? duty_i : stage_q;
    end
    // Unsigned W-bit compare; D >= P is constant high, D = 0 constant low.
    pwm_d = active_i && (cnt_i < shadow_q);
  end

  // Duty tiers and output flop.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge, and all state uses
    // non-blocking assignment so every flop sees pre-edge values.
    if (!rst) begin
      stage_q  <= '0;
      shadow_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      stage_q  <= stage_d;
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule : pwm_channel

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with double-buffered duty, period and mode.
// The top owns the period counter, direction, period/mode tiers, the
// pending flag, boundary detection and the start pulse.
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int unsigned CH = PWM_CH_DEFAULT,
  parameter int unsigned W  = PWM_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,       // synchronous, active-low
  input  logic            en_i,
  input  logic            center_i,
  input  logic [W-1:0]    period_i,
  input  logic [CH*W-1:0] duty_i,
  input  logic            update_i,
  output logic [CH-1:0]   pwm_o,
  output logic            start_o,
  output logic            pending_o
);

  // Period and mode travel together through the staging and shadow tiers.
  typedef struct packed {
    logic [W-1:0] period;
    pwm_mode_e    mode;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{period: '0, mode: PWM_EDGE};

  cfg_t         req_cfg;
  cfg_t         stage_q, stage_d;
  cfg_t         shadow_q, shadow_d;
  logic [W-1:0] cnt_q, cnt_d;
  pwm_dir_e     dir_q, dir_d;
  logic         pending_q, pending_d;
  logic         start_q, start_d;

  logic         period_zero;
  logic [W-1:0] period_last;
  logic         at_end;
  logic         boundary;
  logic         load_shadow;
  logic         active;

  assign req_cfg     = '{period: period_i, mode: pwm_mode_e'(center_i)};
  assign period_zero = (shadow_q.period == '0);
  // Only meaningful when the period is non-zero; never wider than W bits.
  assign period_last = shadow_q.period - W'(1);

  // Last count of the current period in the active shadow mode.
  always_comb begin
    if (shadow_q.mode == PWM_EDGE) begin
      at_end = (cnt_q == period_last);
    end else begin
      at_end = (dir_q == DIR_DOWN) && (cnt_q == '0);
    end
  end

  // Disabled or zero-period cycles all count as boundaries so that any
  // pending configuration lands immediately.
  assign boundary    = !en_i || period_zero || at_end;
  assign load_shadow = boundary && (pending_q || update_i);

  // State register: counter, direction, tiers, pending flag, start pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      dir_q     <= DIR_UP;
      stage_q   <= CFG_RESET;
      shadow_q  <= CFG_RESET;
      pending_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      stage_q   <= stage_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      start_q   <= start_d;
    end
  end

  // Next-state: tier transfers, pending bookkeeping and the up/down count.
  always_comb begin
    stage_d   = stage_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;

    if (update_i) begin
      stage_d = req_cfg;
    end

    if (load_shadow) begin
      shadow_d  = update_i ? req_cfg : stage_q;
      pending_d = 1'b0;
    end else if (update_i) begin
      pending_d = 1'b1;
    end

    if (boundary) begin
      // Every new period, and every reload, restarts at 0 counting up.
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (shadow_q.mode == PWM_EDGE) begin
      cnt_d = cnt_q + W'(1);
    end else if (dir_q == DIR_UP) begin
      if (cnt_q == period_last) begin
        // The turn repeats P-1 once so the period is exactly 2P cycles.
        dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Output decode: channel enable and the start-of-period pulse.
  always_comb begin
    active  = en_i && !period_zero;
    start_d = active && (cnt_q == '0) && (dir_q == DIR_UP);
  end

  // Zero-extend the packed request so the shared slice helper can be used.
  duty_bus_t duty_wide;
  assign duty_wide = duty_bus_t'(duty_i);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [W-1:0] duty_ch;
    assign duty_ch = W'(duty_of(duty_wide, i, W));

    pwm_channel #(
      .W(W)
    ) u_channel (
      .clk          (clk),
      .rst          (rst),
      .cnt_i        (cnt_q),
      .duty_i       (duty_ch),
      .load_stage_i (update_i),
      .load_shadow_i(load_shadow),
      .active_i     (active),
      .pwm_o        (pwm_o[i])
    );
  end

  assign start_o   = start_q;
  assign pending_o = pending_q;

endmodule : pwm_multi
